huff_encoder: RTL and testbench

- Huffman encoder; the transmit end of the bit-chunk stream consumed by the codebase's Huffman decoder.
- Accepts signed 4-bit symbols, maps each to a fixed prefix code of 1-9 bits, and packs the codes into a bit accumulator.
- Emits variable-length chunks of up to 4 bits, in the same out_bits/out_len format the decoder loads.

---
 rtl/huff_encoder_if.sv | 26 ++
 rtl/huff_encoder.sv | 133 +++++++++++++
 tb/tb_huff_encoder.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/huff_encoder_if.sv
// Purpose : symbol-in / chunk-out handshake bundle for huff_encoder.
// Signals : s_valid/s_symbol/s_last/s_ready   - symbol stream into the encoder
//           out_valid/out_bits/out_len/out_last/out_ready - chunk stream out
// Modports: slave  - the encoder (consumes symbols, produces chunks)
//           master - the environment (produces symbols, consumes chunks)
interface huff_encoder_if;
    logic       s_valid;
    logic [3:0] s_symbol;
    logic       s_last;
    logic       s_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_bits;
    logic [2:0] out_len;
    logic       out_last;

    modport slave (
        input  s_valid, s_symbol, s_last, out_ready,
        output s_ready, out_valid, out_bits, out_len, out_last
    );

    modport master (
        output s_valid, s_symbol, s_last, out_ready,
        input  s_ready, out_valid, out_bits, out_len, out_last
    );
endinterface

// File: rtl/huff_encoder.sv
// Purpose : Huffman encoder. Maps signed 4-bit symbols to prefix codes of
//           1..9 bits, packs them MSB-first into a bit accumulator and emits
//           right-aligned chunks of up to CHUNK bits; a frame (ended by
//           s_last) is flushed with exactly one out_last chunk.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-low reset
//           bus   - huff_encoder_if.slave (symbol input, chunk output)
module huff_encoder #(
    parameter int unsigned MAX_CODE = 9,
    parameter int unsigned CHUNK    = 4,
    parameter int unsigned ACC_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    huff_encoder_if.slave      bus
);
    localparam int unsigned CNT_W = $clog2(ACC_W + 1);
    localparam int unsigned LEN_W = $clog2(CHUNK + 1);

    typedef enum logic {ST_ACCEPT, ST_DRAIN} state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_s_ready;
    logic               r_out_valid;
    logic [CHUNK-1:0]   r_out_bits;
    logic [LEN_W-1:0]   r_out_len;
    logic               r_out_last;

    logic [2:0]         w_mag;
    logic [8:0]         w_code_val;
    logic [3:0]         w_code_len;
    logic               w_push;
    logic               w_pop;
    logic [ACC_W-1:0]   w_acc_pop;
    logic [CNT_W-1:0]   w_cnt_pop;
    logic [CNT_W-1:0]   w_shift;
    logic [ACC_W-1:0]   w_acc_n;
    logic [CNT_W-1:0]   w_cnt_n;
    state_t             w_state_n;
    logic               w_valid_n;
    logic [LEN_W-1:0]   w_len_n;
    logic               w_last_n;
    logic [CHUNK-1:0]   w_bits_n;

    // Code table, right-aligned: k ones, a 0, then the sign bit; 0 and -8 special.
    always_comb begin
        w_code_val = '0;
        w_code_len = 4'd1;
        w_mag      = bus.s_symbol[3] ? 3'(-bus.s_symbol) : bus.s_symbol[2:0];
        if (bus.s_symbol == 4'b1000) begin
            w_code_val = 9'b111111110;
            w_code_len = 4'd9;
        end else if (bus.s_symbol != 4'd0) begin
            w_code_val = (((9'd1 << w_mag) - 9'd1) << 2) | {8'd0, bus.s_symbol[3]};
            w_code_len = 4'(w_mag) + 4'd2;
        end
    end

    // Pop first, then append the new code directly after the surviving bits.
    always_comb begin
        w_push    = bus.s_valid && r_s_ready;
        w_pop     = r_out_valid && bus.out_ready;
        w_acc_pop = w_pop ? (r_acc << r_out_len) : r_acc;
        w_cnt_pop = w_pop ? (r_cnt - CNT_W'(r_out_len)) : r_cnt;
        w_shift   = CNT_W'(ACC_W) - w_cnt_pop - CNT_W'(w_code_len);
        w_acc_n   = w_acc_pop;
        w_cnt_n   = w_cnt_pop;
        if (w_push) begin
            w_acc_n = w_acc_pop | (ACC_W'(w_code_val) << w_shift);
            w_cnt_n = w_cnt_pop + CNT_W'(w_code_len);
        end

        w_state_n = r_state;
        case (r_state)
            ST_ACCEPT: if (w_push && bus.s_last) w_state_n = ST_DRAIN;
            ST_DRAIN:  if (w_pop && r_out_last)  w_state_n = ST_ACCEPT;
            default:   w_state_n = ST_ACCEPT;
        endcase
    end

    // Chunk decode from the next-cycle state so the outputs can be registered.
    always_comb begin
        w_valid_n = 1'b0;
        w_len_n   = '0;
        w_last_n  = 1'b0;
        w_bits_n  = '0;
        if (w_state_n == ST_DRAIN) begin
            w_valid_n = (w_cnt_n != '0);
            w_len_n   = (w_cnt_n >= CNT_W'(CHUNK)) ? LEN_W'(CHUNK) : LEN_W'(w_cnt_n);
            w_last_n  = (w_cnt_n <= CNT_W'(CHUNK));
        end else begin
            w_valid_n = (w_cnt_n >= CNT_W'(CHUNK));
            w_len_n   = LEN_W'(CHUNK);
        end
        if (w_valid_n) begin
            w_bits_n = w_acc_n[ACC_W-1 -: CHUNK] >> (LEN_W'(CHUNK) - w_len_n);
        end else begin
            w_len_n  = '0;
            w_last_n = 1'b0;
        end
    end

    // State, accumulator and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_ACCEPT;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_s_ready   <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_bits  <= '0;
            r_out_len   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_acc       <= w_acc_n;
            r_cnt       <= w_cnt_n;
            r_s_ready   <= (w_state_n == ST_ACCEPT) && (w_cnt_n <= CNT_W'(ACC_W - MAX_CODE));
            r_out_valid <= w_valid_n;
            r_out_bits  <= w_bits_n;
            r_out_len   <= w_len_n;
            r_out_last  <= w_last_n;
        end
    end

    assign bus.s_ready   = r_s_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_bits  = r_out_bits;
    assign bus.out_len   = r_out_len;
    assign bus.out_last  = r_out_last;
endmodule

// File: tb/tb_huff_encoder.sv
// Purpose : self-checking bench for huff_encoder. Directed frames with
//           hand-computed chunks, backpressure, mid-frame reset, and a
//           random loopback through a small prefix-code decoder model.
module tb_huff_encoder;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    huff_encoder_if bus();

    huff_encoder dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [3:0] sym, input logic last, input logic rdy);
        bus.s_valid   = v;
        bus.s_symbol  = sym;
        bus.s_last    = last;
        bus.out_ready = rdy;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_bits !== 4'd0 || bus.out_len !== 3'd0 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b b=%b l=%0d last=%b, want all 0",
                     bus.out_valid, bus.out_bits, bus.out_len, bus.out_last);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_s_ready: got %b want 1", bus.s_ready);
        end
    endtask

    task automatic test_zero_symbol;
        drive(1'b1, 4'd0, 1'b1, 1'b1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_bits !== 4'b0000 || bus.out_len !== 3'd1 ||
            bus.out_last !== 1'b1 || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_chunk: got v=%b b=%b l=%0d last=%b rdy=%b, want 1 0000 1 1 0",
                     bus.out_valid, bus.out_bits, bus.out_len, bus.out_last, bus.s_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_after: got v=%b rdy=%b, want v=0 rdy=1", bus.out_valid, bus.s_ready);
        end
    endtask

    // +1 then -1: stream 100101 -> 1001/4 then 01/2 last.
    task automatic test_pair;
        drive(1'b1, 4'd1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL pair_first: got v=%b rdy=%b, want v=0 rdy=1", bus.out_valid, bus.s_ready);
        end
        drive(1'b1, 4'hF, 1'b1, 1'b1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_bits !== 4'b1001 || bus.out_len !== 3'd4 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL pair_chunk0: got v=%b b=%b l=%0d last=%b, want 1 1001 4 0",
                     bus.out_valid, bus.out_bits, bus.out_len, bus.out_last);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_bits !== 4'b0001 || bus.out_len !== 3'd2 || bus.out_last !== 1'b1) begin
            errors++;
            $display("FAIL pair_chunk1: got v=%b b=%b l=%0d last=%b, want 1 0001 2 1",
                     bus.out_valid, bus.out_bits, bus.out_len, bus.out_last);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL pair_after: got v=%b rdy=%b, want v=0 rdy=1", bus.out_valid, bus.s_ready);
        end
    endtask

    // -8 -> 111111110 -> 1111/4, 1111/4, 0/1 last.
    task automatic test_minus8;
        logic [3:0] eb [3];
        logic [2:0] el [3];
        logic       ez [3];
        eb = '{4'b1111, 4'b1111, 4'b0000};
        el = '{3'd4, 3'd4, 3'd1};
        ez = '{1'b0, 1'b0, 1'b1};
        drive(1'b1, 4'b1000, 1'b1, 1'b1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_bits !== eb[i] || bus.out_len !== el[i] || bus.out_last !== ez[i]) begin
                errors++;
                $display("FAIL minus8_chunk%0d: got v=%b b=%b l=%0d last=%b, want 1 %b %0d %b",
                         i, bus.out_valid, bus.out_bits, bus.out_len, bus.out_last, eb[i], el[i], ez[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL minus8_after: got v=%b rdy=%b, want v=0 rdy=1", bus.out_valid, bus.s_ready);
        end
    endtask

    task automatic test_backpressure;
        drive(1'b1, 4'd7, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_bits !== 4'b1111 || bus.out_len !== 3'd4 ||
                bus.out_last !== 1'b0 || bus.s_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got v=%b b=%b l=%0d last=%b rdy=%b, want 1 1111 4 0 0",
                         i, bus.out_valid, bus.out_bits, bus.out_len, bus.out_last, bus.s_ready);
            end
            @(negedge clk);
        end
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_bits !== 4'b1110 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_cnt5: got v=%b b=%b rdy=%b, want 1 1110 1",
                     bus.out_valid, bus.out_bits, bus.s_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.s_ready !== 1'b1 || bus.out_len !== 3'd0) begin
            errors++;
            $display("FAIL release_cnt1: got v=%b rdy=%b l=%0d, want 0 1 0", bus.out_valid, bus.s_ready, bus.out_len);
        end
        // Flush the leftover "0" with a zero symbol: stream "00".
        drive(1'b1, 4'd0, 1'b1, 1'b1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_bits !== 4'b0000 || bus.out_len !== 3'd2 || bus.out_last !== 1'b1) begin
            errors++;
            $display("FAIL flush_tail: got v=%b b=%b l=%0d last=%b, want 1 0000 2 1",
                     bus.out_valid, bus.out_bits, bus.out_len, bus.out_last);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drain;
        drive(1'b1, 4'b1000, 1'b1, 1'b1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_bits !== 4'd0 || bus.out_len !== 3'd0 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%b b=%b l=%0d last=%b, want all 0",
                     bus.out_valid, bus.out_bits, bus.out_len, bus.out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: got rdy=%b v=%b, want 1 0", bus.s_ready, bus.out_valid);
        end
        test_pair();
    endtask

    task automatic test_loopback;
        logic [3:0] exp_syms[$];
        int         frame_sizes[$];
        logic       bits[$];
        logic [3:0] cur_sym;
        logic       cur_last;
        logic       have;
        logic [3:0] dsym;
        logic [3:0] esym;
        int         n_sent;
        int         frame_len;
        int         ndec;
        int         c;
        int         cyc;
        have = 1'b0; n_sent = 0; frame_len = 0; cyc = 0;
        cur_sym = '0; cur_last = 1'b0;
        while ((n_sent < 500 || frame_sizes.size() != 0) && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (!have) begin
                cur_sym  = 4'($urandom_range(0, 15));
                cur_last = ($urandom_range(0, 7) == 0) || (n_sent == 499);
                have     = 1'b1;
            end
            drive((n_sent < 500) && ($urandom_range(0, 4) != 0), cur_sym, cur_last,
                  $urandom_range(0, 2) != 0);
            #1;
            if (bus.s_valid && bus.s_ready) begin
                exp_syms.push_back(cur_sym);
                frame_len++;
                if (cur_last) begin
                    frame_sizes.push_back(frame_len);
                    frame_len = 0;
                end
                n_sent++;
                have = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                for (int b = int'(bus.out_len) - 1; b >= 0; b--) bits.push_back(bus.out_bits[b]);
                if (bus.out_last) begin
                    ndec = 0;
                    while (bits.size() != 0) begin
                        c = 0;
                        while (bits.size() != 0 && bits[0] == 1'b1 && c < 8) begin
                            void'(bits.pop_front());
                            c++;
                        end
                        if (bits.size() == 0) break;
                        void'(bits.pop_front());
                        if (c == 0) dsym = 4'd0;
                        else if (c == 8) dsym = 4'b1000;
                        else begin
                            if (bits.size() == 0) break;
                            dsym = bits.pop_front() ? 4'(-c) : 4'(c);
                        end
                        esym = (exp_syms.size() != 0) ? exp_syms.pop_front() : 4'bxxxx;
                        ndec++;
                        checks++;
                        if (dsym !== esym) begin
                            errors++;
                            $display("FAIL loop_symbol: decoded %0d want %0d", $signed(dsym), $signed(esym));
                        end
                    end
                    checks++;
                    if (frame_sizes.size() == 0 || bits.size() != 0 || ndec != frame_sizes[0]) begin
                        errors++;
                        $display("FAIL loop_frame: decoded %0d symbols, leftover %0d bits, want %0d symbols",
                                 ndec, bits.size(), (frame_sizes.size() != 0) ? frame_sizes[0] : -1);
                    end
                    if (frame_sizes.size() != 0) void'(frame_sizes.pop_front());
                    bits.delete();
                end
            end
        end
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        checks++;
        if (cyc >= 30000 || exp_syms.size() != 0) begin
            errors++;
            $display("FAIL loop_complete: cycles %0d sent %0d undecoded %0d, want all decoded",
                     cyc, n_sent, exp_syms.size());
        end
    endtask

    initial begin
        test_reset();
        test_zero_symbol();
        test_pair();
        test_minus8();
        test_backpressure();
        test_reset_mid_drain();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
